// File: rtl/link_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : link_control
//  Purpose  : Game-loop sequencer for the player character. Paces frames from
//             a free-running divider, priority-encodes the buttons into an
//             action code, and walks the character datapath through
//             init / idle / register / apply / draw map / draw character.
//  Revision : 1.0  initial release
// ============================================================================
module link_control #(
    parameter int FRAME_DIV = 833333
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_attack,
    input  logic       map_done,
    input  logic       draw_done,
    output logic       init,
    output logic       idle,
    output logic       reg_action,
    output logic       apply_action,
    output logic       draw_map,
    output logic       draw_char,
    output logic [2:0] user_input,
    output logic [7:0] frame_overrun
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int                 c_CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FRAME_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [2:0] c_ACT_NONE   = 3'b000;
    localparam logic [2:0] c_ACT_ATTACK = 3'b001;
    localparam logic [2:0] c_ACT_UP     = 3'b010;
    localparam logic [2:0] c_ACT_DOWN   = 3'b011;
    localparam logic [2:0] c_ACT_LEFT   = 3'b100;
    localparam logic [2:0] c_ACT_RIGHT  = 3'b101;

    localparam logic [2:0] c_S_INIT  = 3'd0;
    localparam logic [2:0] c_S_IDLE  = 3'd1;
    localparam logic [2:0] c_S_REG   = 3'd2;
    localparam logic [2:0] c_S_APPLY = 3'd3;
    localparam logic [2:0] c_S_MAP   = 3'd4;
    localparam logic [2:0] c_S_CHAR  = 3'd5;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_count;
    logic               w_tick;
    logic               r_pending;
    logic [7:0]         r_overrun;
    logic [2:0]         r_user_input;
    logic [2:0]         w_action;
    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic               w_frame_start;

    // Tick marks the last cycle of each frame period.
    assign w_tick        = (r_count == c_CNT_LAST);
    // A frame begins from idle on a fresh tick or one that arrived while busy.
    assign w_frame_start = (r_state == c_S_IDLE) && (w_tick || r_pending);

    assign user_input    = r_user_input;
    assign frame_overrun = r_overrun;

    // Free-running frame divider, 0..FRAME_DIV-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_ONE;
        end
    end

    // Remember ticks missed while busy; count ticks lost on top of one pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_overrun <= 8'd0;
        end else if (r_state == c_S_IDLE) begin
            // A tick in idle is consumed directly, never counted as dropped.
            if (w_frame_start) begin
                r_pending <= 1'b0;
            end
        end else if (w_tick) begin
            r_pending <= 1'b1;
            if (r_pending && (r_overrun != 8'hFF)) begin
                r_overrun <= r_overrun + 8'd1;
            end
        end
    end

    // Button priority encoder: attack > up > down > left > right.
    always_comb begin
        w_action = c_ACT_NONE;
        if (key_attack) begin
            w_action = c_ACT_ATTACK;
        end else if (key_up) begin
            w_action = c_ACT_UP;
        end else if (key_down) begin
            w_action = c_ACT_DOWN;
        end else if (key_left) begin
            w_action = c_ACT_LEFT;
        end else if (key_right) begin
            w_action = c_ACT_RIGHT;
        end
    end

    // Action latch: buttons are only observed during the register phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_user_input <= c_ACT_NONE;
        end else if (r_state == c_S_REG) begin
            r_user_input <= w_action;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and one-hot strobe decode of the current state.
    always_comb begin
        w_state_next = r_state;
        init         = 1'b0;
        idle         = 1'b0;
        reg_action   = 1'b0;
        apply_action = 1'b0;
        draw_map     = 1'b0;
        draw_char    = 1'b0;
        case (r_state)
            c_S_INIT: begin
                init         = 1'b1;
                w_state_next = c_S_IDLE;
            end
            c_S_IDLE: begin
                idle = 1'b1;
                if (w_frame_start) begin
                    w_state_next = c_S_REG;
                end
            end
            c_S_REG: begin
                reg_action   = 1'b1;
                w_state_next = c_S_APPLY;
            end
            c_S_APPLY: begin
                apply_action = 1'b1;
                w_state_next = c_S_MAP;
            end
            c_S_MAP: begin
                draw_map = 1'b1;
                if (map_done) begin
                    w_state_next = c_S_CHAR;
                end
            end
            c_S_CHAR: begin
                draw_char = 1'b1;
                if (draw_done) begin
                    w_state_next = c_S_IDLE;
                end
            end
            default: begin
                // Unreachable encodings recover through init.
                w_state_next = c_S_INIT;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_link_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_link_control
//  Purpose  : Self-checking bench for link_control with a frame-level
//             reference model and hand-computed milestone expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_link_control;

    localparam int FD = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_up, key_down, key_left, key_right, key_attack;
    logic       map_done, draw_done;
    logic       init, idle, reg_action, apply_action, draw_map, draw_char;
    logic [2:0] user_input;
    logic [7:0] frame_overrun;
    logic [5:0] w_strobes;

    int n_pass  = 0;
    int n_total = 0;
    int tb_cyc  = 0;
    bit chk_en  = 1'b0;

    // Reference model: phase 0..5 = init, idle, reg, apply, map, char
    int         m_phase = 0;
    bit         m_pend  = 1'b0;
    int         m_over  = 0;
    logic [2:0] m_ui    = 3'b000;

    link_control #(.FRAME_DIV(FD)) dut (
        .clock        (clock),
        .reset        (reset),
        .key_up       (key_up),
        .key_down     (key_down),
        .key_left     (key_left),
        .key_right    (key_right),
        .key_attack   (key_attack),
        .map_done     (map_done),
        .draw_done    (draw_done),
        .init         (init),
        .idle         (idle),
        .reg_action   (reg_action),
        .apply_action (apply_action),
        .draw_map     (draw_map),
        .draw_char    (draw_char),
        .user_input   (user_input),
        .frame_overrun(frame_overrun)
    );

    assign w_strobes = {init, idle, reg_action, apply_action, draw_map, draw_char};

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, tb_cyc, act, exp);
    endtask

    // Action codes 1..5 follow the priority order attack, up, down, left, right.
    function automatic logic [2:0] enc(input logic a, u, d, l, r);
        logic [4:0] keys;
        keys = {r, l, d, u, a};
        for (int i = 0; i < 5; i++) begin
            if (keys[i]) return 3'(i + 1);
        end
        return 3'b000;
    endfunction

    // Model advances once per clock using the inputs presented for that cycle.
    always @(posedge clock) begin
        int  nph;
        bit  tick;
        if (reset) begin
            m_phase = 0; m_pend = 1'b0; m_over = 0; m_ui = 3'b000; tb_cyc = 0;
        end else begin
            tick = ((tb_cyc % FD) == FD - 1);
            nph  = m_phase;
            case (m_phase)
                0: nph = 1;
                1: if (tick || m_pend) nph = 2;
                2: begin nph = 3; m_ui = enc(key_attack, key_up, key_down, key_left, key_right); end
                3: nph = 4;
                4: if (map_done) nph = 5;
                5: if (draw_done) nph = 1;
                default: nph = 0;
            endcase
            if (m_phase == 1) begin
                if (tick || m_pend) m_pend = 1'b0;
            end else if (tick) begin
                if (m_pend && m_over < 255) m_over++;
                m_pend = 1'b1;
            end
            m_phase = nph;
            tb_cyc++;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("strobes", 32'(w_strobes), 32'(6'b100000 >> m_phase));
            check("user_input", 32'(user_input), 32'(m_ui));
            check("frame_overrun", 32'(frame_overrun), 32'(m_over));
        end
    end

    task automatic to_cycle(input int k);
        while (tb_cyc < k) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        {key_up, key_down, key_left, key_right, key_attack} = 5'b0;
        map_done = 1'b1; draw_done = 1'b1;
        @(negedge clock);
        chk_en = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("lit_init_c0", 32'(w_strobes), 32'(6'b100000));
        to_cycle(1);   check("lit_idle_c1",  32'(w_strobes), 32'(6'b010000));
        to_cycle(15);  check("lit_idle_c15", 32'(w_strobes), 32'(6'b010000));
        to_cycle(16);  check("lit_reg_c16",  32'(w_strobes), 32'(6'b001000));
        to_cycle(17);  check("lit_apply_c17",32'(w_strobes), 32'(6'b000100));
        to_cycle(18);  check("lit_map_c18",  32'(w_strobes), 32'(6'b000010));
        to_cycle(19);  check("lit_char_c19", 32'(w_strobes), 32'(6'b000001));
        to_cycle(20);  check("lit_idle_c20", 32'(w_strobes), 32'(6'b010000));
        to_cycle(32);  check("lit_reg_c32",  32'(w_strobes), 32'(6'b001000));
        check("lit_ovr_c32", 32'(frame_overrun), 32'd0);
        // Priority encoding across three frames
        to_cycle(40);  key_up = 1'b1; key_attack = 1'b1;
        to_cycle(49);  check("lit_ui_attack", 32'(user_input), 32'd1);
        to_cycle(56);  key_up = 1'b0; key_attack = 1'b0; key_down = 1'b1; key_right = 1'b1;
        to_cycle(65);  check("lit_ui_down", 32'(user_input), 32'd3);
        to_cycle(72);  key_down = 1'b0; key_right = 1'b0;
        to_cycle(81);  check("lit_ui_none", 32'(user_input), 32'd0);
        // Key change after the register phase is ignored
        to_cycle(90);  key_left = 1'b1;
        to_cycle(98);  key_left = 1'b0; key_right = 1'b1;
        to_cycle(99);  check("lit_ui_left_char", 32'(user_input), 32'd4);
        check("lit_char_c99", 32'(w_strobes), 32'(6'b000001));
        to_cycle(100); check("lit_ui_left_idle", 32'(user_input), 32'd4);
        key_right = 1'b0;
        // Map stall across two ticks
        to_cycle(110); map_done = 1'b0;
        to_cycle(143); check("lit_ovr_c143", 32'(frame_overrun), 32'd0);
        to_cycle(144); check("lit_ovr_c144", 32'(frame_overrun), 32'd1);
        to_cycle(150); check("lit_map_c150", 32'(w_strobes), 32'(6'b000010));
        map_done = 1'b1;
        to_cycle(151); check("lit_char_c151", 32'(w_strobes), 32'(6'b000001));
        to_cycle(152); check("lit_idle_c152", 32'(w_strobes), 32'(6'b010000));
        to_cycle(153); check("lit_reg_c153",  32'(w_strobes), 32'(6'b001000));
        // Lingering draw_done after leaving draw_char
        to_cycle(160); draw_done = 1'b0;
        to_cycle(165); check("lit_char_c165", 32'(w_strobes), 32'(6'b000001));
        draw_done = 1'b1;
        to_cycle(166); check("lit_idle_c166", 32'(w_strobes), 32'(6'b010000));
        to_cycle(167); check("lit_idle_c167", 32'(w_strobes), 32'(6'b010000));
        to_cycle(168); check("lit_idle_c168", 32'(w_strobes), 32'(6'b010000));
        draw_done = 1'b0;
        to_cycle(170); draw_done = 1'b1;
        to_cycle(175); check("lit_idle_c175", 32'(w_strobes), 32'(6'b010000));
        to_cycle(176); check("lit_reg_c176",  32'(w_strobes), 32'(6'b001000));
        // Tick coinciding with draw_char exit
        to_cycle(185); draw_done = 1'b0;
        to_cycle(207); draw_done = 1'b1;
        to_cycle(208); check("lit_idle_c208", 32'(w_strobes), 32'(6'b010000));
        draw_done = 1'b0;
        to_cycle(209); check("lit_reg_c209",  32'(w_strobes), 32'(6'b001000));
        // Tick in idle while pending: no overrun
        to_cycle(235); key_down = 1'b1;
        to_cycle(238); draw_done = 1'b1;
        to_cycle(239); check("lit_idle_c239", 32'(w_strobes), 32'(6'b010000));
        to_cycle(240); check("lit_reg_c240",  32'(w_strobes), 32'(6'b001000));
        map_done = 1'b0;
        to_cycle(241); check("lit_ovr_c241", 32'(frame_overrun), 32'd1);
        check("lit_ui_c241", 32'(user_input), 32'd3);
        key_down = 1'b0;
        // Long stall drives the overrun counter into saturation
        to_cycle(4319); check("lit_ovr_254", 32'(frame_overrun), 32'd254);
        to_cycle(4320); check("lit_ovr_255", 32'(frame_overrun), 32'd255);
        to_cycle(4390); draw_done = 1'b0;
        to_cycle(4400); check("lit_ovr_sat", 32'(frame_overrun), 32'd255);
        check("lit_map_c4400", 32'(w_strobes), 32'(6'b000010));
        map_done = 1'b1;
        // Reset while drawing the character
        to_cycle(4402); check("lit_char_c4402", 32'(w_strobes), 32'(6'b000001));
        reset = 1'b1;
        @(negedge clock);
        check("lit_rst_strobes", 32'(w_strobes), 32'(6'b100000));
        check("lit_rst_ui", 32'(user_input), 32'd0);
        check("lit_rst_ovr", 32'(frame_overrun), 32'd0);
        reset = 1'b0; draw_done = 1'b1;
        to_cycle(1);  check("lit_idle_after_rst", 32'(w_strobes), 32'(6'b010000));
        to_cycle(16); check("lit_reg_after_rst",  32'(w_strobes), 32'(6'b001000));
        to_cycle(20);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
